wr_data_packer: RTL
===================

WR_DATA_PACKER -- requirements
Module: wr_data_packer

Interface
REQ-001 The block SHALL have parameter IN_DATA_WIDTH, default 16, giving the narrow input word width.
REQ-002 The block SHALL have parameter OUT_DATA_WIDTH, default 128, giving the packed output word width. RATIO = OUT_DATA_WIDTH/IN_DATA_WIDTH SHALL be a power of two of at least 2.
REQ-003 wr_clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 wr_rst  input  1  synchronous, active-high reset.
REQ-005 in_en  input  1  input word offered.
REQ-006 in_data  input  IN_DATA_WIDTH  input word.
REQ-007 in_rdy  output  1  block can accept in_data this cycle.
REQ-008 flush  input  1  one-cycle request to emit a partial word.
REQ-009 flush_done  output  1  one-cycle pulse when a flush request is serviced.
REQ-010 pk_en  output  1  packed word valid; drives the write FIFO's wr_en.
REQ-011 pk_data  output  OUT_DATA_WIDTH  packed word.
REQ-012 pk_lanes  output  log2(RATIO)+1  number of valid input lanes in pk_data (1..RATIO).
REQ-013 pk_vld  input  1  downstream FIFO ready (the FIFO's wr_vld).

Function
REQ-014 Accept: the block SHALL accept a word only when in_en=1 and in_rdy=1 in the same cycle.
REQ-015 Accumulator: an accepted word SHALL be written to lane cnt, bits [cnt*IN_DATA_WIDTH +: IN_DATA_WIDTH]; the first word of a packed word lands in the LSBs. cnt SHALL increment modulo RATIO.
REQ-016 Full word: when the accepted word fills lane RATIO-1:
- The complete word SHALL load into the output register at that clock edge.
- pk_en SHALL be 1 in the next cycle, with pk_lanes=RATIO (latency: 1 cycle after the last accept).
- cnt SHALL return to 0 and the accumulator SHALL clear to 0.
REQ-017 Output handshake: a transfer SHALL occur when pk_en=1 and pk_vld=1. pk_en, pk_data and pk_lanes SHALL hold stable until that transfer. pk_en SHALL deassert the cycle after the transfer unless a new word loads at the same edge.
REQ-018 Back-to-back: a new word MAY load at the same edge as a transfer, giving one packed word per RATIO accepts with no bubble.
REQ-019 in_rdy SHALL be combinational and SHALL equal !wr_rst && !flush_pend && (cnt!=RATIO-1 || !pk_en || pk_vld).
REQ-020 Flush request: flush=1 with cnt!=0, or with a word accepted in the same cycle that leaves cnt!=0 afterwards, SHALL set flush_pend.
REQ-021 Flush service: flush_pend SHALL be serviced at the first edge where !pk_en || pk_vld. At that edge:
- The accumulator SHALL load into the output register, with unfilled lanes 0 and pk_lanes = cnt.
- cnt and the accumulator SHALL clear.
- flush_pend SHALL clear.
- flush_done SHALL pulse in the following cycle.
REQ-022 Flush with nothing to emit: flush=1 when cnt=0 after any same-cycle accept SHALL be a no-op, except that flush_done SHALL pulse in the next cycle.
REQ-023 Flush while pending: flush=1 while flush_pend=1 SHALL be ignored and SHALL produce no extra flush_done pulse.
REQ-024 Data integrity: no accepted word SHALL be dropped, duplicated or reordered.

Reset
REQ-025 While wr_rst=1 at an edge, the following SHALL be cleared to 0: cnt, accumulator, flush_pend, pk_en, pk_data, pk_lanes, flush_done.
REQ-026 in_rdy SHALL be 0 while wr_rst=1.
REQ-027 Reset mid-operation SHALL discard any partial or pending word without emitting it.
REQ-028 The first accept after reset SHALL land in lane 0.

Verification
REQ-029 Full word: 8 words 0x0001..0x0008 on consecutive cycles with pk_vld=1 -> one pk_en pulse one cycle after the 8th accept, pk_data=0x0008_0007_0006_0005_0004_0003_0002_0001, pk_lanes=8.
REQ-030 Streaming: 64 words continuous with pk_vld=1 -> in_rdy stays 1 throughout; 8 pk_en pulses spaced exactly 8 cycles apart.
REQ-031 Backpressure: pk_vld=0 with one word held in the output register, then 7 more words accepted -> in_rdy=0 at cnt=7 until pk_vld=1; first word held stable; second word correct with no loss.
REQ-032 Partial flush: 3 words 0xA,0xB,0xC, then flush -> pk_data=0x...000C_000B_000A (upper lanes zero), pk_lanes=3; flush_done pulses one cycle after service.
REQ-033 Empty flush: flush with cnt=0 -> no pk_en; flush_done pulses next cycle.
REQ-034 Reset mid-word: 5 words accepted, then wr_rst for 1 cycle, then 8 new words -> the 5 old words are never emitted; the first packed word holds only the new data.

Source files
------------

// File: rtl/wr_data_packer.sv
// -----------------------------------------------------------------------------
// wr_data_packer
//
// Packs a stream of narrow input words into wide words for a write FIFO.
// The first accepted word of a packed word lands in the least significant
// lane.  A full packed word is emitted automatically; a flush request emits
// whatever partial word is in the accumulator, with unfilled lanes zero.
//
// Ports
//   wr_clk     in   single clock, rising edge
//   wr_rst     in   synchronous active-high reset
//   in_en      in   input word offered
//   in_data    in   input word (IN_DATA_WIDTH)
//   in_rdy     out  input word can be accepted this cycle (combinational)
//   flush      in   one-cycle request to emit the partial word
//   flush_done out  one-cycle pulse once a flush request has been serviced
//   pk_en      out  packed word valid (FIFO wr_en)
//   pk_data    out  packed word (OUT_DATA_WIDTH)
//   pk_lanes   out  number of valid lanes in pk_data (1..RATIO)
//   pk_vld     in   downstream FIFO ready
// -----------------------------------------------------------------------------
module wr_data_packer #(
   parameter  int IN_DATA_WIDTH  = 16,
   parameter  int OUT_DATA_WIDTH = 128,
   localparam int RATIO          = OUT_DATA_WIDTH / IN_DATA_WIDTH,
   localparam int CNT_W          = $clog2(RATIO),
   localparam int LANE_W         = CNT_W + 1
) (
   input  logic                      wr_clk,
   input  logic                      wr_rst,
   input  logic                      in_en,
   input  logic [IN_DATA_WIDTH-1:0]  in_data,
   output logic                      in_rdy,
   input  logic                      flush,
   output logic                      flush_done,
   output logic                      pk_en,
   output logic [OUT_DATA_WIDTH-1:0] pk_data,
   output logic [LANE_W-1:0]         pk_lanes,
   input  logic                      pk_vld
);

   localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(RATIO - 1);
   localparam logic [LANE_W-1:0] LANES_FULL = LANE_W'(RATIO);

   logic [OUT_DATA_WIDTH-1:0] acc_p0;
   logic [CNT_W-1:0]          cnt_p0;
   logic                      flush_pend;

   logic                      out_free;
   logic                      accept;
   logic                      last_lane;
   logic [OUT_DATA_WIDTH-1:0] acc_wr;
   logic [CNT_W-1:0]          cnt_wr;

   // Stage 0: accept decision and accumulator lane write
   always_comb begin
      out_free  = !pk_en || pk_vld;
      // Only the word that completes a packed word needs a free output
      // register; earlier lanes can keep filling under backpressure.
      in_rdy    = !wr_rst && !flush_pend && (cnt_p0 != CNT_MAX || out_free);
      accept    = in_en && in_rdy;
      last_lane = accept && (cnt_p0 == CNT_MAX);
      acc_wr    = acc_p0;
      if (accept) begin
         acc_wr[cnt_p0*IN_DATA_WIDTH +: IN_DATA_WIDTH] = in_data;
      end
      cnt_wr    = accept ? cnt_p0 + 1'b1 : cnt_p0;
   end

   // Stage 1: output register, flush sequencing
   always_ff @(posedge wr_clk) begin
      if (wr_rst) begin
         acc_p0     <= '0;
         cnt_p0     <= '0;
         flush_pend <= 1'b0;
         pk_en      <= 1'b0;
         pk_data    <= '0;
         pk_lanes   <= '0;
         flush_done <= 1'b0;
      end else begin
         flush_done <= 1'b0;
         // A load below overrides this so back-to-back words have no bubble.
         if (pk_en && pk_vld) begin
            pk_en <= 1'b0;
         end

         if (flush_pend) begin
            // in_rdy is low while pending, so no accept can race the service.
            if (out_free) begin
               pk_en      <= 1'b1;
               pk_data    <= acc_p0;
               pk_lanes   <= {1'b0, cnt_p0};
               acc_p0     <= '0;
               cnt_p0     <= '0;
               flush_pend <= 1'b0;
               flush_done <= 1'b1;
            end
         end else if (last_lane) begin
            pk_en    <= 1'b1;
            pk_data  <= acc_wr;
            pk_lanes <= LANES_FULL;
            acc_p0   <= '0;
            cnt_p0   <= '0;
            // The same-cycle accept left nothing partial: flush is a no-op.
            if (flush) begin
               flush_done <= 1'b1;
            end
         end else begin
            acc_p0 <= acc_wr;
            cnt_p0 <= cnt_wr;
            if (flush) begin
               if (cnt_wr != '0) begin
                  flush_pend <= 1'b1;
               end else begin
                  flush_done <= 1'b1;
               end
            end
         end
      end
   end

endmodule
